// File: rtl/reg_alu_sequencer_pkg.sv
// Shared definitions for the register-file/ALU instruction sequencer:
// FSM state encodings, opcode/opext constants and instruction field positions.
package reg_alu_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_PAUSE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Instruction fields: [15:12] opcode, [11:8] Rdest, [7:4] opext, [3:0] Rsrc/Imm
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned RD_LSB   = 8;
    localparam int unsigned EXT_LSB  = 4;
    localparam int unsigned RS_LSB   = 0;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_CMP  = 4'hB;

    localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

    // Compare instructions only update flags, never the register file
    function automatic logic is_cmp(input logic [3:0] opcode, input logic [3:0] opext);
        return ((opcode == OP_RTYPE) && (opext == EXT_CMP)) || (opcode == OP_CMPI);
    endfunction

endpackage

// File: rtl/reg_alu_instr_decode.sv
// Combinational instruction decoder: splits the latched instruction into
// regfile addresses, ALU opcode, sign-extended immediate and write intent.
module reg_alu_instr_decode
    import reg_alu_sequencer_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [7:0]  alu_op,
    output logic [15:0] imm,
    output logic        imm_sel,
    output logic        writes_reg
);

    logic [3:0] opcode;
    logic [3:0] opext;

    // Field extraction and operand-select decode
    always_comb begin
        opcode     = instr[OPC_LSB +: 4];
        opext      = instr[EXT_LSB +: 4];
        ra         = instr[RD_LSB +: 4];
        rb         = instr[RS_LSB +: 4];
        alu_op     = {opcode, opext};
        imm        = {{12{instr[RS_LSB + 3]}}, instr[RS_LSB +: 4]};
        imm_sel    = (opcode != OP_RTYPE);
        writes_reg = !is_cmp(opcode, opext);
    end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller driving the
// regfile + ALU datapath from an external instruction ROM.
module reg_alu_sequencer
    import reg_alu_sequencer_pkg::*;
#(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned PROG_LEN  = 16,
    parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic            clk,
    input  logic            resetIN,
    input  logic            start,
    input  logic            step_mode,
    input  logic            step,
    output logic [PC_W-1:0] instr_addr,
    input  logic [15:0]     instr_data,
    output logic [3:0]      reg_ra,
    output logic [3:0]      reg_rb,
    output logic [7:0]      alu_op,
    output logic [15:0]     imm,
    output logic            imm_sel,
    output logic            reg_we,
    output logic [3:0]      reg_wa,
    output logic            flags_we,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      state_dbg
);

    // Compare is one bit wider than pc so PROG_LEN = 2^PC_W halts instead of wrapping
    localparam logic [PC_W:0] PROG_END = PROG_LEN[PC_W:0];

    state_t          state;
    logic [15:0]     instr_q;
    logic            writes_reg;
    logic [PC_W:0]   pc_inc_w;
    logic [PC_W-1:0] pc_inc;

    assign instr_addr = pc;
    assign state_dbg  = state;

    // Next program counter, wide form used for the end-of-program test
    always_comb begin
        pc_inc_w = {1'b0, pc} + {{PC_W{1'b0}}, 1'b1};
        pc_inc   = pc_inc_w[PC_W-1:0];
    end

    // Datapath controls come only from the latched instruction, never from instr_data
    reg_alu_instr_decode u_decode (
        .instr      (instr_q),
        .ra         (reg_ra),
        .rb         (reg_rb),
        .alu_op     (alu_op),
        .imm        (imm),
        .imm_sel    (imm_sel),
        .writes_reg (writes_reg)
    );

    // Sequencer FSM with pc, instruction register and registered strobes
    always_ff @(posedge clk) begin
        if (resetIN) begin
            state    <= S_IDLE;
            pc       <= '0;
            instr_q  <= '0;
            reg_we   <= 1'b0;
            reg_wa   <= '0;
            flags_we <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            reg_we   <= 1'b0;
            flags_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    instr_q <= instr_data;
                    if (instr_data == HALT_WORD) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: state <= S_WB;
                S_WB: begin
                    // Strobes are registered here so they appear the cycle after WB
                    flags_we <= 1'b1;
                    reg_we   <= writes_reg;
                    reg_wa   <= instr_q[RD_LSB +: 4];
                    pc       <= pc_inc;
                    if (pc_inc_w == PROG_END) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_HALT;
                    end else if (step_mode) begin
                        state <= S_PAUSE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_PAUSE: begin
                    if (step || !step_mode) state <= S_FETCH;
                end
                S_HALT: begin
                    if (start) begin
                        pc    <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Directed bench for reg_alu_sequencer with a one-cycle-latency ROM model.
module tb_reg_alu_sequencer;

    logic        clk = 1'b0;
    logic        resetIN = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data = '0;
    logic [3:0]  reg_ra, reg_rb, reg_wa;
    logic [7:0]  alu_op;
    logic [15:0] imm;
    logic        imm_sel, reg_we, flags_we, busy, done;
    logic [7:0]  pc;
    logic [2:0]  state_dbg;

    logic [15:0] rom [0:15];
    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned we_cnt;

    always #5 clk = ~clk;

    // ROM data valid one cycle after address
    always @(posedge clk) instr_data <= rom[instr_addr[3:0]];

    reg_alu_sequencer #(.PC_W(8), .PROG_LEN(4), .HALT_WORD(16'hFFFF)) u_dut (
        .clk(clk), .resetIN(resetIN), .start(start), .step_mode(step_mode), .step(step),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .reg_ra(reg_ra), .reg_rb(reg_rb), .alu_op(alu_op), .imm(imm), .imm_sel(imm_sel),
        .reg_we(reg_we), .reg_wa(reg_wa), .flags_we(flags_we), .busy(busy), .done(done),
        .pc(pc), .state_dbg(state_dbg)
    );

    task automatic tick(input int unsigned n = 1);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;

        // Reset state
        tick(2);
        resetIN = 1'b0;
        chk("rst_state", state_dbg, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_aluop", alu_op, 0);

        // Reset mid-EXEC of ADD R1,R2
        rom[0] = 16'h0152; rom[1] = 16'h530F; rom[2] = 16'hFFFF;
        pulse_start();
        tick(2);
        chk("mid_exec_state", state_dbg, 3);
        resetIN = 1'b1; tick(); resetIN = 1'b0;
        chk("rexec_state", state_dbg, 0);
        chk("rexec_pc", pc, 0);
        chk("rexec_we", reg_we, 0);
        chk("rexec_busy", busy, 0);
        tick(3);
        chk("rexec_idle_hold", state_dbg, 0);

        // Reset during WB drops the write
        pulse_start();
        tick(3);
        chk("mid_wb_state", state_dbg, 4);
        resetIN = 1'b1; tick(); resetIN = 1'b0;
        chk("rwb_we", reg_we, 0);
        chk("rwb_pc", pc, 0);

        // Main program: ADD R1,R2 ; ADDI R3,#-1 ; HALT
        pulse_start();                     // cycle 1
        chk("c1_fetch", state_dbg, 1);
        chk("c1_busy", busy, 1);
        tick(2);                           // cycle 3
        chk("c3_exec", state_dbg, 3);
        chk("c3_aluop", alu_op, 8'h05);
        chk("c3_ra", reg_ra, 1);
        chk("c3_rb", reg_rb, 2);
        chk("c3_immsel", imm_sel, 0);
        tick();                            // cycle 4
        chk("c4_we", reg_we, 0);
        tick();                            // cycle 5
        chk("c5_we", reg_we, 1);
        chk("c5_wa", reg_wa, 1);
        chk("c5_flags", flags_we, 1);
        chk("c5_pc", pc, 1);
        tick();                            // cycle 6
        chk("c6_we", reg_we, 0);
        tick();                            // cycle 7
        chk("c7_aluop", alu_op, 8'h50);
        chk("c7_imm", imm, 16'hFFFF);
        chk("c7_immsel", imm_sel, 1);
        chk("c7_ra", reg_ra, 3);
        tick(2);                           // cycle 9
        chk("c9_we", reg_we, 1);
        chk("c9_wa", reg_wa, 3);
        tick(2);                           // cycle 11
        chk("c11_done", done, 1);
        chk("c11_busy", busy, 0);
        chk("c11_state", state_dbg, 6);
        chk("c11_pc", pc, 2);

        // Compare instructions from HALT: CMP R4,R5 ; CMPI R1,#3 ; HALT
        rom[0] = 16'h04B5; rom[1] = 16'hB123; rom[2] = 16'hFFFF;
        pulse_start();
        chk("cmp_restart_pc", pc, 0);
        chk("cmp_restart_done", done, 0);
        chk("cmp_restart_busy", busy, 1);
        tick(4);
        chk("cmp1_flags", flags_we, 1);
        chk("cmp1_we", reg_we, 0);
        chk("cmp1_pc", pc, 1);
        tick(4);
        chk("cmp2_flags", flags_we, 1);
        chk("cmp2_we", reg_we, 0);
        chk("cmp2_pc", pc, 2);
        tick(2);
        chk("cmp_done", done, 1);

        // Step mode, three instructions
        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'hFFFF;
        step_mode = 1'b1;
        pulse_start();
        tick(4);
        chk("st1_pause", state_dbg, 5);
        chk("st1_we", reg_we, 1);
        chk("st1_pc", pc, 1);
        pulse_start();
        tick(2);
        chk("st1_start_ign", state_dbg, 5);
        chk("st1_pc_hold", pc, 1);
        step = 1'b1; tick(); step = 1'b0;
        chk("st2_fetch", state_dbg, 1);
        tick(4);
        chk("st2_pause", state_dbg, 5);
        chk("st2_pc", pc, 2);
        step = 1'b1; tick(); step = 1'b0;
        tick(4);
        chk("st3_pause", state_dbg, 5);
        chk("st3_pc", pc, 3);
        step_mode = 1'b0;
        tick();
        chk("st_release_fetch", state_dbg, 1);
        tick(2);
        chk("st_halt", done, 1);
        chk("st_halt_pc", pc, 3);

        // PROG_LEN=4 with no HALT word, run twice
        rom[0] = 16'h1010; rom[1] = 16'h2020; rom[2] = 16'h3030; rom[3] = 16'h4040;
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            we_cnt = 0;
            for (int i = 0; i < 40 && !done; i++) begin
                tick();
                if (reg_we) we_cnt++;
            end
            chk($sformatf("plen_run%0d_we_cnt", r), we_cnt, 4);
            chk($sformatf("plen_run%0d_done", r), done, 1);
            chk($sformatf("plen_run%0d_pc", r), pc, 4);
        end

        // start and reset in the same cycle: reset wins
        start = 1'b1; resetIN = 1'b1;
        tick();
        start = 1'b0; resetIN = 1'b0;
        chk("sr_state", state_dbg, 0);
        chk("sr_busy", busy, 0);
        chk("sr_done", done, 0);
        tick();
        chk("sr_state_hold", state_dbg, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
